target_mover: RTL and testbench
===============================

# target_mover

Frame-rate motion controller for the concentric target. It owns the target's centre, advances it once per video frame with edge bounce, and freezes and hides it for a fixed number of frames after a hit. It then respawns the target at a pseudo-random position. Outputs are the registered top-left bounding-box corners of the four rings, which feed the `circles` renderer's `x..x3` / `y..y3` inputs directly.

## Interface
- `RADIUS`, 384: outer ring radius (px).
- `RADIUS1`, 288: ring 1 radius.
- `RADIUS2`, 192: ring 2 radius.
- `RADIUS3`, 96: inner ring radius.
- `HRES`, 1024: active width.
- `VRES`, 768: active height.
- `HOLD_FRAMES`, 60: frames the target stays hidden after a hit (≥1).
- `SEED`, 16'hACE1: LFSR reset value (nonzero).
- `clk`  in  1  pixel clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `vsync`  in  1  active-low vertical sync from the VGA timing generator, synchronous to `clk`.
- `speed`  in  4  pixels moved per frame on each axis (0 = stationary).
- `freeze`  in  1  level; while high, no movement and the hold counter does not advance.
- `hit`  in  1  one-cycle pulse from hit detection.
- `x`, `x1`, `x2`, `x3`  out  11  ring bounding-box left edges.
- `y`, `y1`, `y2`, `y3`  out  10  ring bounding-box top edges.
- `hidden`  out  1  high while in HOLD; downstream blanks the target.
- `frame_tick`  out  1  one-cycle pulse when a new frame's positions appear.

## Operation
- Centre registers: `cx` (11b), `cy` (10b), and direction bits `dirx`, `diry` (1 = increasing).
- Outputs: `x = cx−RADIUS`, `x1 = cx−RADIUS1`, `x2 = cx−RADIUS2`, `x3 = cx−RADIUS3`; the `y..y3` outputs are formed the same way from `cy`. All are registered.
- Bounds: `CX_MIN = RADIUS`, `CX_MAX = HRES−1−RADIUS`, `CY_MIN = RADIUS`, `CY_MAX = VRES−1−RADIUS`.
  - If an axis has `MAX < MIN`, that axis is frozen at `HRES/2` or `VRES/2`.
  - With the defaults, the y axis is frozen at `cy = 384`.
- Arithmetic: next position is computed in 12-bit signed as `c ± speed`.
  - If the result is `> MAX`: `c = MAX`, direction flips.
  - If the result is `< MIN`: `c = MIN`, direction flips.
  - Otherwise `c = result`, direction kept.
- Frame event: falling edge of `vsync`, detected against the previous sampled value.
- States:
  - MOVE: on a frame event with `freeze = 0`, apply a step. `hit = 1` → HOLD with `hold_cnt = 0`; no step is taken that frame, even if it coincides with a frame event.
  - HOLD: `hidden = 1`, position unchanged. On each frame event with `freeze = 0`, `hold_cnt++`. When `hold_cnt` reaches `HOLD_FRAMES` → RESPAWN.
  - RESPAWN (1 clk):
    - `cx = min(CX_MIN + lfsr[9:0], CX_MAX)`.
    - `cy = min(CY_MIN + lfsr[15:7], CY_MAX)`.
    - `dirx = lfsr[0]`, `diry = lfsr[1]`.
    - Frozen axes keep their fixed value.
    - → MOVE.
- `hit` is ignored in HOLD and RESPAWN.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every `clk`.

## Timing
- Reset values (asynchronous; also applied on reset mid-operation):
  - State MOVE, `hold_cnt = 0`, `lfsr = SEED`.
  - `cx = clamp(HRES/2)` = 512, `cy = 384`, `dirx = diry = 1`.
  - Outputs: `x = 128`, `x1 = 224`, `x2 = 320`, `x3 = 416`; `y = 0`, `y1 = 96`, `y2 = 192`, `y3 = 288`.
  - `hidden = 0`, `frame_tick = 0`.
- Latency: if edge E is the first clock edge to sample `vsync` low, new positions and `frame_tick` appear after edge E+1.
- At most one update per frame. Outputs change only during vertical sync, so there is no mid-frame tearing.
- `hidden` rises on the edge after `hit` is sampled, and falls on the edge that leaves RESPAWN.

## Structure
- Package `target_pkg`: `HRES`/`VRES` and radius defaults, the state enum (MOVE, HOLD, RESPAWN), and the LFSR tap constant.
- Sub-module `lfsr16` (`clk`, `reset_n`, seed parameter, 16-bit state out).

## Test plan
- Reset, then `speed = 4`, 3 vsync falls → `x = 132, 136, 140`; `y` stays 0; one `frame_tick` per frame, 2 cycles after each fall.
- Force `cx = 637`, `dirx = 1`, `speed = 4` → next frame `cx = 639` (`x = 255`), `dirx = 0`; following frame `cx = 635`.
- `hit` pulse → `hidden = 1` next cycle, positions frozen for 60 frames, then new position within `[384, 639]` and `hidden = 0`; a second `hit` during HOLD has no effect.
- `hit` coincident with a frame event in MOVE → no step, HOLD entered.
- `freeze = 1` for 10 frames in MOVE and in HOLD → positions and `hold_cnt` unchanged, `frame_tick` still pulses.
- Assert `reset_n = 0` mid-HOLD → all outputs return to reset values immediately; `speed = 0` → position constant across frames.

Source files
------------

// File: rtl/target_pkg.sv
// Shared constants and types for the target motion controller.
package target_pkg;

    // Default screen geometry and ring radii (px)
    localparam int DEF_HRES    = 1024;
    localparam int DEF_VRES    = 768;
    localparam int DEF_RADIUS  = 384;
    localparam int DEF_RADIUS1 = 288;
    localparam int DEF_RADIUS2 = 192;
    localparam int DEF_RADIUS3 = 96;

    // Fibonacci taps 16,14,13,11 expressed as a mask over state[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        MOVE,
        HOLD,
        RESPAWN
    } state_t;

endpackage

// File: rtl/target_mover_lfsr16.sv
// 16-bit Fibonacci LFSR, free-running every clock; feeds respawn positions.
module lfsr16
    import target_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] state
);

    // Shift left, new LSB is the XOR of the tapped bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SEED;
        else          state <= {state[14:0], ^(state & LFSR_TAPS)};
    end

endmodule

// File: rtl/target_mover.sv
// Per-frame target motion: bounce between bounds, hide for a number of
// frames after a hit, then respawn at an LFSR-derived position.
module target_mover
    import target_pkg::*;
#(
    parameter int          RADIUS      = DEF_RADIUS,
    parameter int          RADIUS1     = DEF_RADIUS1,
    parameter int          RADIUS2     = DEF_RADIUS2,
    parameter int          RADIUS3     = DEF_RADIUS3,
    parameter int          HRES        = DEF_HRES,
    parameter int          VRES        = DEF_VRES,
    parameter int          HOLD_FRAMES = 60,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic [3:0]  speed,
    input  logic        freeze,
    input  logic        hit,
    output logic [10:0] x,
    output logic [10:0] x1,
    output logic [10:0] x2,
    output logic [10:0] x3,
    output logic [9:0]  y,
    output logic [9:0]  y1,
    output logic [9:0]  y2,
    output logic [9:0]  y3,
    output logic        hidden,
    output logic        frame_tick
);

    localparam int CX_MIN = RADIUS;
    localparam int CX_MAX = HRES - 1 - RADIUS;
    localparam int CY_MIN = RADIUS;
    localparam int CY_MAX = VRES - 1 - RADIUS;
    // An axis whose bounds cross cannot move and sits at screen centre
    localparam bit X_FROZEN = CX_MAX < CX_MIN;
    localparam bit Y_FROZEN = CY_MAX < CY_MIN;
    localparam int CX_RST = X_FROZEN ? HRES / 2 :
                            (HRES / 2 < CX_MIN) ? CX_MIN :
                            (HRES / 2 > CX_MAX) ? CX_MAX : HRES / 2;
    localparam int CY_RST = Y_FROZEN ? VRES / 2 :
                            (VRES / 2 < CY_MIN) ? CY_MIN :
                            (VRES / 2 > CY_MAX) ? CY_MAX : VRES / 2;
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic signed [11:0] CXMIN_S = 12'(CX_MIN);
    localparam logic signed [11:0] CXMAX_S = 12'(CX_MAX);
    localparam logic signed [11:0] CYMIN_S = 12'(CY_MIN);
    localparam logic signed [11:0] CYMAX_S = 12'(CY_MAX);

    state_t            state;
    logic [HW-1:0]     hold_cnt;
    logic [10:0]       cx;
    logic [9:0]        cy;
    logic              dirx, diry;
    logic              vs_q, tick_pend, fe;
    logic [15:0]       lfsr;
    logic signed [11:0] nx, ny;
    logic [11:0]       rx, ry;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .state   (lfsr)
    );

    // Candidate step and respawn positions; sign bit catches underflow
    always_comb begin
        fe = vs_q & ~vsync;
        nx = dirx ? $signed({1'b0, cx}) + $signed({8'd0, speed})
                  : $signed({1'b0, cx}) - $signed({8'd0, speed});
        ny = diry ? $signed({2'b0, cy}) + $signed({8'd0, speed})
                  : $signed({2'b0, cy}) - $signed({8'd0, speed});
        rx = 12'(CX_MIN) + {2'b0, lfsr[9:0]};
        ry = 12'(CY_MIN) + {3'b0, lfsr[15:7]};
    end

    // Motion FSM: step on frame events, hold after hit, respawn once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= MOVE;
            hold_cnt  <= '0;
            cx        <= 11'(CX_RST);
            cy        <= 10'(CY_RST);
            dirx      <= 1'b1;
            diry      <= 1'b1;
            vs_q      <= 1'b1;
            tick_pend <= 1'b0;
            hidden    <= 1'b0;
        end else begin
            vs_q      <= vsync;
            tick_pend <= fe;
            case (state)
                MOVE: begin
                    if (hit) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                        hidden   <= 1'b1;
                    end else if (fe && !freeze) begin
                        if (!X_FROZEN) begin
                            if (nx > CXMAX_S) begin
                                cx <= 11'(CX_MAX); dirx <= ~dirx;
                            end else if (nx < CXMIN_S) begin
                                cx <= 11'(CX_MIN); dirx <= ~dirx;
                            end else begin
                                cx <= nx[10:0];
                            end
                        end
                        if (!Y_FROZEN) begin
                            if (ny > CYMAX_S) begin
                                cy <= 10'(CY_MAX); diry <= ~diry;
                            end else if (ny < CYMIN_S) begin
                                cy <= 10'(CY_MIN); diry <= ~diry;
                            end else begin
                                cy <= ny[9:0];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (fe && !freeze) begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HW'(HOLD_FRAMES - 1)) state <= RESPAWN;
                    end
                end
                RESPAWN: begin
                    if (!X_FROZEN) begin
                        cx   <= (rx > 12'(CX_MAX)) ? 11'(CX_MAX) : rx[10:0];
                        dirx <= lfsr[0];
                    end
                    if (!Y_FROZEN) begin
                        cy   <= (ry > 12'(CY_MAX)) ? 10'(CY_MAX) : ry[9:0];
                        diry <= lfsr[1];
                    end
                    hidden <= 1'b0;
                    state  <= MOVE;
                end
                default: state <= MOVE;
            endcase
        end
    end

    // Ring corners and frame tick, one clock behind the centre registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x  <= 11'(CX_RST - RADIUS);
            x1 <= 11'(CX_RST - RADIUS1);
            x2 <= 11'(CX_RST - RADIUS2);
            x3 <= 11'(CX_RST - RADIUS3);
            y  <= 10'(CY_RST - RADIUS);
            y1 <= 10'(CY_RST - RADIUS1);
            y2 <= 10'(CY_RST - RADIUS2);
            y3 <= 10'(CY_RST - RADIUS3);
            frame_tick <= 1'b0;
        end else begin
            x  <= cx - 11'(RADIUS);
            x1 <= cx - 11'(RADIUS1);
            x2 <= cx - 11'(RADIUS2);
            x3 <= cx - 11'(RADIUS3);
            y  <= cy - 10'(RADIUS);
            y1 <= cy - 10'(RADIUS1);
            y2 <= cy - 10'(RADIUS2);
            y3 <= cy - 10'(RADIUS3);
            frame_tick <= tick_pend;
        end
    end

endmodule

// File: tb/tb_target_mover.sv
// Directed bench for target_mover: table of per-frame moves plus
// hand-written boundary, hit/hold/respawn and reset sequences.
module tb_target_mover;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vsync = 1'b1;
    logic [3:0]  speed = 4'd0;
    logic        freeze = 1'b0;
    logic        hit = 1'b0;
    logic [10:0] x, x1, x2, x3;
    logic [9:0]  y, y1, y2, y3;
    logic        hidden, frame_tick;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] spd;
        logic       frz;
        int         ex;
    } vec_t;
    vec_t vecs[8];

    target_mover dut (
        .clk(clk), .reset_n(reset_n), .vsync(vsync), .speed(speed),
        .freeze(freeze), .hit(hit),
        .x(x), .x1(x1), .x2(x2), .x3(x3),
        .y(y), .y1(y1), .y2(y2), .y3(y3),
        .hidden(hidden), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // All four ring corners on each axis from the expected outer corner
    task automatic chk_pos(input string name, input int ex, input int ey);
        chk({name, "_x"},  32'(x),  32'(ex));
        chk({name, "_x1"}, 32'(x1), 32'(ex + 96));
        chk({name, "_x2"}, 32'(x2), 32'(ex + 192));
        chk({name, "_x3"}, 32'(x3), 32'(ex + 288));
        chk({name, "_y"},  32'(y),  32'(ey));
        chk({name, "_y1"}, 32'(y1), 32'(ey + 96));
        chk({name, "_y2"}, 32'(y2), 32'(ey + 192));
        chk({name, "_y3"}, 32'(y3), 32'(ey + 288));
    endtask

    // One vsync low period; frame_tick must pulse only after the second edge
    task automatic frame(input logic with_hit);
        logic t0, t1, t2;
        @(negedge clk); vsync = 1'b0; hit = with_hit;
        @(posedge clk); #1 t0 = frame_tick;
        @(negedge clk); hit = 1'b0;
        @(posedge clk); #1 t1 = frame_tick;
        t2 = 1'b0;
        repeat (3) begin @(posedge clk); #1 t2 |= frame_tick; end
        @(negedge clk); vsync = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("tick", 32'({t0, t1, t2}), 32'(3'b010));
    endtask

    task automatic pulse_hit();
        @(negedge clk); hit = 1'b1;
        @(posedge clk); #1 chk("hidden_on_hit", 32'(hidden), 32'd1);
        @(negedge clk); hit = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd4,  1'b0, 132};
        vecs[1] = '{4'd4,  1'b0, 136};
        vecs[2] = '{4'd4,  1'b0, 140};
        vecs[3] = '{4'd0,  1'b0, 140};
        vecs[4] = '{4'd4,  1'b1, 140};
        vecs[5] = '{4'd15, 1'b0, 155};
        vecs[6] = '{4'd1,  1'b0, 156};
        vecs[7] = '{4'd4,  1'b1, 156};

        // Reset state
        repeat (3) @(posedge clk);
        #1 chk_pos("reset", 128, 0);
        chk("reset_hidden", 32'(hidden), 32'd0);
        chk("reset_tick", 32'(frame_tick), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table-driven frame moves
        for (int i = 0; i < 8; i++) begin
            speed = vecs[i].spd;
            freeze = vecs[i].frz;
            frame(1'b0);
            chk_pos($sformatf("vec%0d", i), vecs[i].ex, 0);
        end
        freeze = 1'b0;

        // Right boundary: 512 + 25*5 = 637, then clamp at 639 and reverse
        do_reset();
        speed = 4'd5;
        for (int i = 0; i < 25; i++) frame(1'b0);
        chk_pos("pre_edge", 253, 0);
        speed = 4'd4;
        frame(1'b0);
        chk_pos("clamp_max", 255, 0);
        frame(1'b0);
        chk_pos("after_max", 251, 0);
        // Left boundary: walk down by 15 to 395, clamp at 384, reverse
        speed = 4'd15;
        for (int k = 1; k <= 16; k++) begin
            frame(1'b0);
            chk($sformatf("down%0d_x", k), 32'(x), 32'(251 - 15 * k));
        end
        frame(1'b0);
        chk_pos("clamp_min", 0, 0);
        frame(1'b0);
        chk_pos("after_min", 15, 0);

        // Hit, hold with a repeated hit and a frozen stretch, then respawn
        speed = 4'd4;
        pulse_hit();
        for (int i = 0; i < 5; i++) frame(1'b0);
        pulse_hit();
        freeze = 1'b1;
        for (int i = 0; i < 10; i++) frame(1'b0);
        freeze = 1'b0;
        for (int i = 0; i < 54; i++) frame(1'b0);
        chk("hold59_hidden", 32'(hidden), 32'd1);
        chk_pos("hold59", 15, 0);
        frame(1'b0);
        chk("respawn_hidden", 32'(hidden), 32'd0);
        chk("respawn_x_range", 32'(x <= 11'd255), 32'd1);
        chk("respawn_y", 32'(y), 32'd0);

        // Hit on the same cycle as a frame event: no step, hold entered
        do_reset();
        speed = 4'd4;
        frame(1'b0);
        chk_pos("pre_coinc", 132, 0);
        frame(1'b1);
        chk_pos("coinc", 132, 0);
        chk("coinc_hidden", 32'(hidden), 32'd1);
        for (int i = 0; i < 3; i++) frame(1'b0);
        chk_pos("coinc_hold", 132, 0);

        // Asynchronous reset mid-hold
        @(negedge clk); reset_n = 1'b0;
        #1 chk_pos("async_rst", 128, 0);
        chk("async_rst_hidden", 32'(hidden), 32'd0);
        chk("async_rst_tick", 32'(frame_tick), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Stationary at speed 0, frozen in move, then one step
        speed = 4'd0;
        for (int i = 0; i < 3; i++) frame(1'b0);
        chk_pos("speed0", 128, 0);
        speed = 4'd4;
        freeze = 1'b1;
        for (int i = 0; i < 10; i++) frame(1'b0);
        chk_pos("freeze_move", 128, 0);
        freeze = 1'b0;
        frame(1'b0);
        chk_pos("unfreeze", 132, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
